// File: rtl/bcd_serial_collector_pkg.sv
// Shared definitions for the serial BCD collector.
// Contents:
//   BITS_PER_DIGIT, BCD_MAX  - digit framing and the largest legal BCD value
//   SEG_0 .. SEG_9           - active-high {g,f,e,d,c,b,a} patterns
//   SEG_BLANK                - all segments off (active-high)
//   seg_pattern()            - maps a 4-bit value to its pattern, blank if > 9
package bcd_serial_collector_pkg;

    localparam int         BITS_PER_DIGIT = 4;
    localparam logic [3:0] BCD_MAX        = 4'd9;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    function automatic logic [6:0] seg_pattern(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bcd_seg_decoder.sv
// Combinational 4-bit BCD to 7-segment decoder.
// Ports:
//   bcd    in  4  digit value; values above 9 show as blank
//   blank  in  1  forces all segments off
//   seg    out 7  {g,f,e,d,c,b,a}, inverted when SEG_ACTIVE_LOW=1
module bcd_seg_decoder
    import bcd_serial_collector_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    logic [6:0] seg_hi;

    // NOTE: give every always_comb output a default first so no path leaves it
    // unassigned; an unassigned path would infer a latch.
    always_comb begin
        seg_hi = SEG_BLANK;
        if (!blank) begin
            seg_hi = seg_pattern(bcd);
        end
    end

    // Polarity is applied last so "blank" means all segments dark either way.
    assign seg = SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;

endmodule

// File: rtl/bcd_serial_collector.sv
// Collects the LSB-first serial BCD stream from the Excess-3 to BCD converter
// into 4-bit digits, keeps a history of the last NDIG good digits, flags
// non-BCD nibbles and drives a 7-segment display of the newest good digit.
// Ports:
//   Clk         in  1       clock, rising edge
//   Rst         in  1       asynchronous active-low reset
//   En          in  1       bit strobe; Din is consumed only when En=1
//   Din         in  1       serial BCD bit, LSB first
//   Digit       out 4       last completed nibble, good or bad
//   DigitValid  out 1       one-cycle pulse when a new nibble lands on Digit
//   DigitErr    out 1       high while Digit holds a nibble > 9
//   Digits      out 4*NDIG  history, [3:0] is the newest good digit
//   DigitCount  out 4       good digits received, saturating at NDIG
//   Seg         out 7       {g,f,e,d,c,b,a} of the newest good digit
module bcd_serial_collector
    import bcd_serial_collector_pkg::*;
#(
    parameter int NDIG           = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              En,
    input  logic              Din,
    output logic [3:0]        Digit,
    output logic              DigitValid,
    output logic              DigitErr,
    output logic [4*NDIG-1:0] Digits,
    output logic [3:0]        DigitCount,
    output logic [6:0]        Seg
);

    localparam int         CNT_W    = $clog2(BITS_PER_DIGIT);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BITS_PER_DIGIT - 1);
    localparam logic [3:0] NDIG_L   = 4'(NDIG);

    logic [CNT_W-1:0]  bit_cnt;
    logic [3:0]        shift;
    logic [3:0]        nib;
    logic              nib_good;
    logic [4*NDIG-1:0] digits_next;

    // Nibble as it would stand after taking the current bit; on the fourth
    // bit this is the completed digit, LSB first.
    assign nib      = {Din, shift[3:1]};
    assign nib_good = (nib <= BCD_MAX);

    generate
        if (NDIG == 1) begin : g_hist_one
            assign digits_next = nib;
        end else begin : g_hist_many
            assign digits_next = {Digits[4*NDIG-5:0], nib};
        end
    endgenerate

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            bit_cnt    <= '0;
            shift      <= '0;
            Digit      <= '0;
            DigitValid <= 1'b0;
            DigitErr   <= 1'b0;
            Digits     <= '0;
            DigitCount <= '0;
        end else begin
            DigitValid <= 1'b0;
            if (En) begin
                shift   <= nib;
                bit_cnt <= bit_cnt + 1'b1;
                if (bit_cnt == LAST_BIT) begin
                    Digit      <= nib;
                    DigitValid <= 1'b1;
                    DigitErr   <= !nib_good;
                    // Bad nibbles are reported on Digit but never enter history.
                    if (nib_good) begin
                        Digits <= digits_next;
                        if (DigitCount != NDIG_L) begin
                            DigitCount <= DigitCount + 4'd1;
                        end
                    end
                end
            end
        end
    end

    bcd_seg_decoder #(
        .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
    ) u_seg (
        .bcd   (Digits[3:0]),
        .blank (DigitCount == 4'd0),
        .seg   (Seg)
    );

endmodule

// File: doc/bcd_serial_collector.md
Name: bcd_serial_collector

Overview:
- Downstream consumer of the serial Excess-3 to BCD converter.
- Assembles the converter's LSB-first serial BCD output into 4-bit digits and keeps the last NDIG digits in a history register.
- Flags any non-BCD nibble (value > 9) and drives a 7-segment pattern for the most recent good digit.
- Shares the converter's reset, so digit framing stays aligned with the converter's bit phase.

Parameters:
- NDIG, 4, number of digits held in the history register (1..8).
- SEG_ACTIVE_LOW, 0, 1 inverts all Seg outputs.

Ports:
- Clk  input  1  clock; all state changes on the rising edge.
- Rst  input  1  reset, asynchronous, active-low; clock Clk.
- En  input  1  bit strobe; Din is consumed only when En=1.
- Din  input  1  serial BCD bit, LSB first; must be stable at the sampling Clk edge.
- Digit  output  4  last completed nibble, good or bad.
- DigitValid  output  1  one-cycle pulse, a new nibble is on Digit.
- DigitErr  output  1  level; 1 while Digit holds a nibble > 9.
- Digits  output  4*NDIG  history; [3:0] is newest good digit.
- DigitCount  output  4  good digits received, saturating at NDIG.
- Seg  output  7  {g,f,e,d,c,b,a} pattern of newest good digit.

Behaviour:
- Reset (Rst=0, asynchronous, no Clk edge required):
  - bit_cnt=0, shift=0, Digit=0, DigitValid=0, DigitErr=0, Digits=0, DigitCount=0.
  - Seg is blank: all segments off, after SEG_ACTIVE_LOW polarity is applied.
- Rst asserted mid-digit discards the partial nibble. The first En bit after release is bit 0 of a new digit.
- Bit capture: on a rising edge with En=1, shift <= {Din, shift[3:1]} and bit_cnt <= bit_cnt+1 mod 4.
- En=0 holds all state. DigitValid is still cleared on that edge.
- Digit completion, on the edge where En=1 and bit_cnt==3:
  - nib = {Din, shift[3:1]}.
  - Registered on the same edge: Digit <= nib, DigitValid <= 1, DigitErr <= (nib > 9).
  - Latency: Digit, DigitValid and DigitErr are visible 1 cycle after the 4th bit edge.
- DigitValid is high for exactly one cycle per completed nibble, then returns to 0. Back-to-back digits (En held high) give one pulse every 4 cycles.
- History update, only when nib <= 9:
  - Digits <= {Digits[4*NDIG-5:0], nib}; the oldest digit drops off. For NDIG=1, Digits <= nib.
  - DigitCount <= min(DigitCount+1, NDIG).
  - Bad nibbles leave Digits and DigitCount unchanged.
- DigitErr holds until the next completed nibble or reset. It is not sticky across good digits.
- Seg:
  - Combinational decode of Digits[3:0].
  - Blank while DigitCount==0.
  - A bad nibble does not change Seg.
  - Patterns (active-high, gfedcba): 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
  - Output inverted when SEG_ACTIVE_LOW=1.
- Reset during the cycle a DigitValid pulse would appear: reset wins and no pulse is seen.

Decomposition:
- Shared package:
  - the 10 segment constants and SEG_BLANK=7'b0000000;
  - BITS_PER_DIGIT=4, BCD_MAX=9.
- One sub-module, bcd_seg_decoder: a pure combinational 4-bit to 7-segment map with a blank input and a polarity parameter.
- Everything else stays in the top module: bit counter, shifter, history, count.

Test Plan:
- Reset then En=1 with Din=1,0,1,0 → one cycle after the 4th bit: Digit=5, DigitValid=1 for 1 cycle, DigitErr=0, Digits[3:0]=5, DigitCount=1, Seg=1101101.
- Digits 1,2,3,4,9 streamed back-to-back with NDIG=4 → Digits=16'h2349, DigitCount=4 (saturated), DigitValid pulses exactly every 4 cycles.
- Nibble 1100 (bits 0,0,1,1) after a good digit 7 → Digit=12, DigitErr=1, Digits and DigitCount unchanged, Seg still 0000111. The following digit 3 clears DigitErr to 0.
- En toggled 0/1 randomly while sending 9 (1,0,0,1) → same result as contiguous bits: Digit=9, exactly one DigitValid pulse.
- Rst pulsed low after 2 bits of a digit, without a Clk edge, then a clean 0 (0,0,0,0) → all outputs zero immediately at reset. After release: Digit=0, DigitCount=1, Seg=0111111.
- SEG_ACTIVE_LOW=1 with reset only → Seg=1111111 (blank). After digit 8 → Seg=0000000.
